// File: rtl/wb_stage.sv
// Writeback stage: holds one retiring instruction, waits for load data when needed,
// formats it, and hands rd/wdata/wen/next_pc to the register file. Optional macro: WB_INSTRET_EN.
module wb_stage #(
  parameter int          ADDR_WIDTH = 5,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h3000_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_wen,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic [31:0]           in_next_pc,
  input  logic                  in_is_load,
  input  logic [2:0]            in_load_fmt,
  input  logic [1:0]            in_addr_lo,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH-1:0] wb_waddr,
  output logic [DATA_WIDTH-1:0] wb_wdata,
  output logic                  wb_wen,
  output logic [31:0]           wb_next_pc,
  output logic                  busy,
  output logic [63:0]           minstret
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    SEND     = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] fmt_q;
  logic [1:0] addr_lo_q;

  // Byte/halfword extraction after shifting the addressed byte down to bit 0;
  // a halfword at offset 3 picks up zeros above the last byte.
  function automatic logic [DATA_WIDTH-1:0] format_load(
    input logic [2:0]            fmt,
    input logic [1:0]            lo,
    input logic [DATA_WIDTH-1:0] raw
  );
    logic [DATA_WIDTH-1:0] s;
    s = raw >> {lo, 3'b000};
    case (fmt)
      3'b000:  format_load = {{(DATA_WIDTH-8){s[7]}}, s[7:0]};
      3'b001:  format_load = {{(DATA_WIDTH-16){s[15]}}, s[15:0]};
      3'b100:  format_load = {{(DATA_WIDTH-8){1'b0}}, s[7:0]};
      3'b101:  format_load = {{(DATA_WIDTH-16){1'b0}}, s[15:0]};
      default: format_load = raw;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      rd_valid   <= 1'b0;
      wb_waddr   <= '0;
      wb_wdata   <= '0;
      wb_wen     <= 1'b0;
      wb_next_pc <= RESET_PC;
      fmt_q      <= '0;
      addr_lo_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            wb_waddr   <= in_rd;
            wb_wen     <= in_wen && (in_rd != '0);
            wb_next_pc <= in_next_pc;
            fmt_q      <= in_load_fmt;
            addr_lo_q  <= in_addr_lo;
            in_ready   <= 1'b0;
            if (in_is_load) begin
              state <= WAIT_MEM;
            end else begin
              wb_wdata <= in_result;
              rd_valid <= 1'b1;
              state    <= SEND;
            end
          end
        end
        WAIT_MEM: begin
          if (mem_rvalid) begin
            wb_wdata <= format_load(fmt_q, addr_lo_q, mem_rdata);
            rd_valid <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          rd_valid <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      instret_q <= '0;
    end else if (rd_valid && rd_ready) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign minstret = instret_q;
`else
  assign minstret = '0;
`endif

endmodule
